dsp_mac_pipe: RTL and testbench

- Parametrised successor to the team's fixed-width DSP48A1-style slice.
- Datapath: signed pre-adder (D±B), multiplier (×A), then post-adder/subtractor with selectable Z operand (zero, C, P feedback for accumulate, PCIN) and carry-in.
- Adds a valid/ready streaming handshake with full-pipeline backpressure and generic operand widths.
- Sits between sample sources and downstream filter/accumulator stages; cascades through PCIN/PCOUT.

---
 rtl/dsp_mac_pipe.sv | 177 +++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 3-stage signed pre-add / multiply / post-add MAC with valid-ready backpressure.
// Optional build macro DSP_MAC_SAT_EN: saturate p and flag overflow instead of wrapping.

module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [A_WIDTH-1:0]          a,
  input  logic signed [B_WIDTH-1:0]          b,
  input  logic signed [B_WIDTH-1:0]          d,
  input  logic signed [C_WIDTH-1:0]          c,
  input  logic signed [P_WIDTH-1:0]          pcin,
  input  logic                               carryin,
  input  logic [4:0]                         opmode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [P_WIDTH-1:0]          p,
  output logic signed [P_WIDTH-1:0]          pcout,
  output logic signed [A_WIDTH+B_WIDTH-1:0]  m,
  output logic                               carryout,
  output logic                               overflow
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;
`ifdef DSP_MAC_SAT_EN
  localparam int E_WIDTH = P_WIDTH + 2;
`else
  localparam int E_WIDTH = P_WIDTH + 1;
`endif

  logic w_stall;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  logic                       r_s1_valid;
  logic signed [A_WIDTH-1:0]  r_s1_a;
  logic signed [B_WIDTH-1:0]  r_s1_b;
  logic signed [B_WIDTH-1:0]  r_s1_d;
  logic signed [C_WIDTH-1:0]  r_s1_c;
  logic signed [P_WIDTH-1:0]  r_s1_pcin;
  logic                       r_s1_carryin;
  logic [4:0]                 r_s1_opmode;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every stage samples pre-edge values.
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_d       <= '0;
      r_s1_c       <= '0;
      r_s1_pcin    <= '0;
      r_s1_carryin <= 1'b0;
      r_s1_opmode  <= '0;
    end else if (!w_stall) begin
      r_s1_valid   <= in_valid;
      r_s1_a       <= a;
      r_s1_b       <= b;
      r_s1_d       <= d;
      r_s1_c       <= c;
      r_s1_pcin    <= pcin;
      r_s1_carryin <= carryin;
      r_s1_opmode  <= opmode;
    end
  end

  logic signed [B_WIDTH-1:0] w_pre;
  logic signed [M_WIDTH-1:0] w_a_ext;
  logic signed [M_WIDTH-1:0] w_pre_ext;
  logic signed [M_WIDTH-1:0] w_prod;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_pre unassigned (no inferred latch).
    w_pre = r_s1_b;
    if (r_s1_opmode[0]) begin
      w_pre = r_s1_opmode[1] ? (r_s1_d - r_s1_b) : (r_s1_d + r_s1_b);
    end
  end

  assign w_a_ext   = {{B_WIDTH{r_s1_a[A_WIDTH-1]}}, r_s1_a};
  assign w_pre_ext = {{A_WIDTH{w_pre[B_WIDTH-1]}}, w_pre};
  assign w_prod    = w_a_ext * w_pre_ext;

  logic                       r_s2_valid;
  logic signed [M_WIDTH-1:0]  r_s2_m;
  logic signed [C_WIDTH-1:0]  r_s2_c;
  logic signed [P_WIDTH-1:0]  r_s2_pcin;
  logic                       r_s2_carryin;
  logic                       r_s2_sub;
  logic [1:0]                 r_s2_zsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_m       <= '0;
      r_s2_c       <= '0;
      r_s2_pcin    <= '0;
      r_s2_carryin <= 1'b0;
      r_s2_sub     <= 1'b0;
      r_s2_zsel    <= '0;
    end else if (!w_stall) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_m       <= w_prod;
      r_s2_c       <= r_s1_c;
      r_s2_pcin    <= r_s1_pcin;
      r_s2_carryin <= r_s1_carryin;
      r_s2_sub     <= r_s1_opmode[2];
      r_s2_zsel    <= r_s1_opmode[4:3];
    end
  end

  // Post-adder runs wide enough to be exact, so carryout and overflow fall out of the top bits.
  logic signed [E_WIDTH-1:0] w_x;
  logic signed [E_WIDTH-1:0] w_z;
  logic signed [E_WIDTH-1:0] w_cin;
  logic signed [E_WIDTH-1:0] w_sum;
  logic signed [P_WIDTH-1:0] w_p_next;

  assign w_x   = {{(E_WIDTH-M_WIDTH){r_s2_m[M_WIDTH-1]}}, r_s2_m};
  assign w_cin = {{(E_WIDTH-1){1'b0}}, r_s2_carryin};

  always_comb begin
    w_z = '0;
    case (r_s2_zsel)
      2'b01:   w_z = {{(E_WIDTH-C_WIDTH){r_s2_c[C_WIDTH-1]}}, r_s2_c};
      2'b10:   w_z = {{(E_WIDTH-P_WIDTH){p[P_WIDTH-1]}}, p};
      2'b11:   w_z = {{(E_WIDTH-P_WIDTH){r_s2_pcin[P_WIDTH-1]}}, r_s2_pcin};
      default: w_z = '0;
    endcase
  end

  assign w_sum = r_s2_sub ? (w_z - (w_x + w_cin)) : (w_z + w_x + w_cin);

`ifdef DSP_MAC_SAT_EN
  logic w_ovf;
  assign w_ovf    = (w_sum[E_WIDTH-1] != w_sum[P_WIDTH-1]) || (w_sum[P_WIDTH] != w_sum[P_WIDTH-1]);
  assign w_p_next = !w_ovf ? w_sum[P_WIDTH-1:0]
                  : (w_sum[E_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                      : {1'b0, {(P_WIDTH-1){1'b1}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (!w_stall && r_s2_valid) begin
      overflow <= w_ovf;
    end
  end
`else
  assign w_p_next = w_sum[P_WIDTH-1:0];
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      m         <= '0;
      carryout  <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        p        <= w_p_next;
        m        <= r_s2_m;
        carryout <= w_sum[P_WIDTH];
      end
    end
  end

  assign pcout = p;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed and randomized checks of dsp_mac_pipe against an arithmetic
// reference model and an in-order result queue.

module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int CW = 48;
  localparam int PW = 48;
  localparam int MW = AW + BW;
  localparam longint PMAX = (longint'(1) << (PW-1)) - 1;
  localparam longint PMIN = -(longint'(1) << (PW-1));

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [AW-1:0]   a;
  logic signed [BW-1:0]   b;
  logic signed [BW-1:0]   d;
  logic signed [CW-1:0]   c;
  logic signed [PW-1:0]   pcin;
  logic                   carryin;
  logic [4:0]             opmode;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [PW-1:0]   p;
  logic signed [PW-1:0]   pcout;
  logic signed [MW-1:0]   m;
  logic                   carryout;
  logic                   overflow;

  dsp_mac_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .pcout(pcout), .m(m),
    .carryout(carryout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    logic [MW-1:0] m;
    logic          co;
    logic          ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint model_p = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic longint wrap_s(input longint v, input int w);
    longint r;
    r = v & ((longint'(1) << w) - 1);
    if (r >= (longint'(1) << (w-1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Reference: plain signed arithmetic on the beat being accepted right now.
  function automatic void model_accept();
    longint     pre, prod, z, res;
    logic [63:0] rv;
    logic [63:0] mv;
    exp_t       e;
    if (!opmode[0])     pre = longint'(b);
    else if (opmode[1]) pre = longint'(d) - longint'(b);
    else                pre = longint'(d) + longint'(b);
    pre  = wrap_s(pre, BW);
    prod = longint'(a) * pre;
    case (opmode[4:3])
      2'd0:    z = 0;
      2'd1:    z = longint'(c);
      2'd2:    z = model_p;
      default: z = longint'(pcin);
    endcase
    if (opmode[2]) res = z - (prod + longint'(carryin));
    else           res = z + prod + longint'(carryin);
    rv    = res;
    e.co  = rv[PW];
    e.ovf = 1'b0;
`ifdef DSP_MAC_SAT_EN
    if (res > PMAX) begin
      res = PMAX; e.ovf = 1'b1;
    end else if (res < PMIN) begin
      res = PMIN; e.ovf = 1'b1;
    end
`endif
    rv  = res;
    mv  = prod;
    e.p = rv[PW-1:0];
    e.m = mv[MW-1:0];
    model_p = wrap_s(res, PW);
    exp_q.push_back(e);
  endfunction

  // One clock: handshakes are evaluated mid-cycle, then the bench resyncs 1 time unit after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL result_unexpected: got p=%h with no beat outstanding", p);
      end else begin
        e = exp_q.pop_front();
        if (p !== e.p || pcout !== e.p || m !== e.m || carryout !== e.co || overflow !== e.ovf) begin
          n_errors++;
          $display("FAIL result: got p=%h pcout=%h m=%h co=%b ovf=%b, expected p=%h m=%h co=%b ovf=%b",
                   p, pcout, m, carryout, overflow, e.p, e.m, e.co, e.ovf);
        end
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [AW-1:0] ta, input logic signed [BW-1:0] tb,
                       input logic signed [BW-1:0] td, input logic signed [CW-1:0] tc,
                       input logic tcin, input logic [4:0] top);
    in_valid = 1'b1;
    a = ta; b = tb; d = td; c = tc; pcin = '0;
    carryin = tcin; opmode = top;
  endtask

  task automatic send_one(input logic signed [AW-1:0] ta, input logic signed [BW-1:0] tb,
                          input logic signed [BW-1:0] td, input logic signed [CW-1:0] tc,
                          input logic tcin, input logic [4:0] top);
    drive(ta, tb, td, tc, tcin, top);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (p !== '0 || pcout !== '0 || m !== '0 || carryout !== 1'b0 ||
        overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: got p=%h pcout=%h m=%h co=%b ovf=%b ov=%b ir=%b, expected zeros with in_ready=1",
               p, pcout, m, carryout, overflow, out_valid, in_ready);
    end
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_multiply_c();
    drive(18'sd3, 18'sd5, 18'sd0, 48'sd10, 1'b0, 5'b01000);
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL latency_c1: got out_valid=%b, expected 0", out_valid);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL latency_c2: got out_valid=%b, expected 0", out_valid);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || p !== 48'd25 || m !== 36'd15) begin
      n_errors++;
      $display("FAIL mult_c: got ov=%b p=%0d m=%0d, expected ov=1 p=25 m=15", out_valid, p, m);
    end
    drain();
  endtask

  task automatic test_preadder();
    send_one(18'sd2, 18'sd4, 18'sd7, 48'sd0, 1'b0, 5'b00001);
    n_checks++;
    if (out_valid !== 1'b1 || p !== 48'd22) begin
      n_errors++; $display("FAIL preadd_sum: got ov=%b p=%0d, expected ov=1 p=22", out_valid, p);
    end
    drain();
    send_one(18'sd2, 18'sd4, 18'sd7, 48'sd0, 1'b0, 5'b00011);
    n_checks++;
    if (out_valid !== 1'b1 || p !== 48'd6) begin
      n_errors++; $display("FAIL preadd_diff: got ov=%b p=%0d, expected ov=1 p=6", out_valid, p);
    end
    drain();
    send_one(-18'sd3, 18'sd5, 18'sd0, 48'sd0, 1'b0, 5'b00000);
    n_checks++;
    if (p !== 48'hFFFF_FFFF_FFF1 || m !== 36'hF_FFFF_FFF1) begin
      n_errors++; $display("FAIL negative_mult: got p=%h m=%h, expected p=fffffffffff1 m=ffffffff1", p, m);
    end
    drain();
  endtask

  task automatic test_subtract_carry();
    send_one(18'sd5, 18'sd6, 18'sd0, 48'sd100, 1'b1, 5'b01100);
    n_checks++;
    if (p !== 48'd69 || carryout !== 1'b0) begin
      n_errors++; $display("FAIL sub_pos: got p=%0d co=%b, expected p=69 co=0", p, carryout);
    end
    drain();
    send_one(18'sd1, 18'sd1, 18'sd0, 48'sd0, 1'b1, 5'b01100);
    n_checks++;
    if (p !== 48'hFFFF_FFFF_FFFE || carryout !== 1'b1) begin
      n_errors++; $display("FAIL sub_borrow: got p=%h co=%b, expected p=fffffffffffe co=1", p, carryout);
    end
    drain();
  endtask

  task automatic test_accumulate();
    int k;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) drive(18'sd1, 18'(i), 18'sd0, 48'sd0, 1'b0, (i == 1) ? 5'b00000 : 5'b10000);
      else in_valid = 1'b0;
      cycle();
      if (i >= 3) begin
        k = i - 2;
        n_checks++;
        if (out_valid !== 1'b1 || p !== PW'(k * (k + 1) / 2)) begin
          n_errors++;
          $display("FAIL accumulate_%0d: got ov=%b p=%0d, expected ov=1 p=%0d", k, out_valid, p, k * (k + 1) / 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(18'(i), 18'sd10, 18'sd0, 48'sd0, 1'b0, 5'b00000);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || p !== 48'd10) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: got ir=%b ov=%b p=%0d, expected ir=0 ov=1 p=10", i, in_ready, out_valid, p);
      end
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      cycle();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || p !== PW'(10 * i)) begin
        n_errors++;
        $display("FAIL stall_release_%0d: got ir=%b ov=%b p=%0d, expected ir=1 ov=1 p=%0d", i, in_ready, out_valid, p, 10 * i);
      end
    end
    drain();
  endtask

  task automatic test_saturation();
    send_one(18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 1'b0, 5'b01000);
`ifdef DSP_MAC_SAT_EN
    n_checks++;
    if (p !== 48'h7FFF_FFFF_FFFF || overflow !== 1'b1 || carryout !== 1'b0) begin
      n_errors++; $display("FAIL sat_clamp: got p=%h ovf=%b co=%b, expected p=7fffffffffff ovf=1 co=0", p, overflow, carryout);
    end
    drain();
    send_one(18'sd1, 18'sd1, 18'sd0, 48'sd5, 1'b0, 5'b01000);
    n_checks++;
    if (p !== 48'd6 || overflow !== 1'b0) begin
      n_errors++; $display("FAIL sat_clear: got p=%0d ovf=%b, expected p=6 ovf=0", p, overflow);
    end
`else
    n_checks++;
    if (p !== 48'h8000_0000_0000 || overflow !== 1'b0 || carryout !== 1'b0) begin
      n_errors++; $display("FAIL wrap: got p=%h ovf=%b co=%b, expected p=800000000000 ovf=0 co=0", p, overflow, carryout);
    end
`endif
    drain();
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(18'sd3, 18'sd5, 18'sd0, 48'sd0, 1'b0, 5'b00000);
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (p !== '0 || m !== '0 || carryout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_midstream: got p=%h m=%h co=%b ov=%b ir=%b, expected zeros with in_ready=1",
               p, m, carryout, out_valid, in_ready);
    end
    exp_q.delete();
    model_p = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++; $display("FAIL reset_flush_%0d: got ov=%b ir=%b, expected ov=0 ir=1", i, out_valid, in_ready);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = AW'($urandom);
      b         = BW'($urandom);
      d         = BW'($urandom);
      c         = CW'({$urandom, $urandom});
      pcin      = PW'({$urandom, $urandom});
      carryin   = 1'($urandom);
      opmode    = 5'($urandom);
      cycle();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; d = '0; c = '0; pcin = '0; carryin = 1'b0; opmode = '0;
    test_reset();
    test_multiply_c();
    test_preadder();
    test_subtract_carry();
    test_accumulate();
    test_backpressure();
    test_saturation();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
